// File: rtl/regs_pkg.sv
// Shared constants and word types for the parametrised register file.
// Default geometry matches the original 8x32 file's 32-bit word and the CPU's 32 GPRs.
package regs_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_DEF  = 32;
    localparam int ADDR_W_DEF = $clog2(DEPTH_DEF);

    localparam int ZERO_REG = 0;

    typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
    typedef logic [DATA_W_DEF-1:0] reg_data_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending-write scoreboard: issue sets, write-back clears, set wins on a tie.
// Bit for the zero register never sets.
module reg_scoreboard
    import regs_pkg::*;
#(
    parameter  int DEPTH  = DEPTH_DEF,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              cr,
    input  logic              issue,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr_w,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    output logic [DEPTH-1:0]  busy_vec,
    output logic              busy_a,
    output logic              busy_b
);

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_nxt;

    // Clear first, then set, so a retiring write and a new issue to the same
    // register leave the newer write pending.
    always_comb begin
        busy_nxt = busy_q;
        for (int i = 1; i < DEPTH; i++) begin
            if (we && (addr_w == ADDR_W'(i))) begin
                busy_nxt[i] = 1'b0;
            end
            if (issue && (addr_i == ADDR_W'(i))) begin
                busy_nxt[i] = 1'b1;
            end
        end
        busy_nxt[ZERO_REG] = 1'b0;
    end

    always_ff @(posedge clk or negedge cr) begin
        if (!cr) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_nxt;
        end
    end

    assign busy_vec = busy_q;
    assign busy_a   = busy_q[addr_a];
    assign busy_b   = busy_q[addr_b];

endmodule

// File: rtl/regs_file_np.sv
// Parametrised 2-read/1-write register file with hardwired zero register and scoreboard.
// Optional write-to-read forwarding is enabled by defining REGS_FILE_BYPASS_EN.
module regs_file_np
    import regs_pkg::*;
#(
    parameter  int DATA_W = DATA_W_DEF,
    parameter  int DEPTH  = DEPTH_DEF,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              cr,
    input  logic              WE,
    input  logic [ADDR_W-1:0] Addr_W,
    input  logic [DATA_W-1:0] Di,
    input  logic [ADDR_W-1:0] Addr_A,
    input  logic [ADDR_W-1:0] Addr_B,
    output logic [DATA_W-1:0] QA,
    output logic [DATA_W-1:0] QB,
    input  logic              Issue,
    input  logic [ADDR_W-1:0] Addr_I,
    output logic              Busy_A,
    output logic              Busy_B,
    output logic [DEPTH-1:0]  Busy_vec
);

    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] stored_a;
    logic [DATA_W-1:0] stored_b;
    logic              sb_busy_a;
    logic              sb_busy_b;
    logic              wr_en;

    assign wr_en = WE && (Addr_W != ZERO_ADDR);

    always_ff @(posedge clk or negedge cr) begin
        if (!cr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[Addr_W] <= Di;
        end
    end

    assign stored_a = (Addr_A == ZERO_ADDR) ? '0 : mem[Addr_A];
    assign stored_b = (Addr_B == ZERO_ADDR) ? '0 : mem[Addr_B];

    reg_scoreboard #(
        .DEPTH (DEPTH)
    ) u_scoreboard (
        .clk      (clk),
        .cr       (cr),
        .issue    (Issue),
        .addr_i   (Addr_I),
        .we       (WE),
        .addr_w   (Addr_W),
        .addr_a   (Addr_A),
        .addr_b   (Addr_B),
        .busy_vec (Busy_vec),
        .busy_a   (sb_busy_a),
        .busy_b   (sb_busy_b)
    );

`ifdef REGS_FILE_BYPASS_EN
    logic byp_a;
    logic byp_b;

    assign byp_a = wr_en && (Addr_W == Addr_A);
    assign byp_b = wr_en && (Addr_W == Addr_B);

    assign QA = byp_a ? Di : stored_a;
    assign QB = byp_b ? Di : stored_b;

    // A retiring write clears busy early, but a same-cycle re-issue is not
    // forwarded, so the register then shows its flop state.
    assign Busy_A = (byp_a && !(Issue && (Addr_I == Addr_A))) ? 1'b0 : sb_busy_a;
    assign Busy_B = (byp_b && !(Issue && (Addr_I == Addr_B))) ? 1'b0 : sb_busy_b;
`else
    assign QA     = stored_a;
    assign QB     = stored_b;
    assign Busy_A = sb_busy_a;
    assign Busy_B = sb_busy_b;
`endif

endmodule

// File: tb/tb_regs_file_np.sv
// Directed, table-driven bench for regs_file_np at its default 32x32 geometry.
module tb_regs_file_np;
    import regs_pkg::*;

    logic        clk = 1'b0;
    logic        cr;
    logic        WE;
    logic [4:0]  Addr_W;
    logic [31:0] Di;
    logic [4:0]  Addr_A;
    logic [4:0]  Addr_B;
    logic [31:0] QA;
    logic [31:0] QB;
    logic        Issue;
    logic [4:0]  Addr_I;
    logic        Busy_A;
    logic        Busy_B;
    logic [31:0] Busy_vec;

    int checks = 0;
    int errors = 0;

    regs_file_np dut (
        .clk      (clk),
        .cr       (cr),
        .WE       (WE),
        .Addr_W   (Addr_W),
        .Di       (Di),
        .Addr_A   (Addr_A),
        .Addr_B   (Addr_B),
        .QA       (QA),
        .QB       (QB),
        .Issue    (Issue),
        .Addr_I   (Addr_I),
        .Busy_A   (Busy_A),
        .Busy_B   (Busy_B),
        .Busy_vec (Busy_vec)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  aw;
        logic [31:0] di;
        logic        iss;
        logic [4:0]  ai;
        logic [4:0]  a;
        logic [4:0]  b;
        logic [31:0] qa;
        logic [31:0] qb;
        logic        ba;
        logic        bb;
        logic [31:0] vec;
    } vec_t;

    vec_t tv[17];

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [4:0] aw, input logic [31:0] di,
                                input logic iss, input logic [4:0] ai,
                                input logic [4:0] a, input logic [4:0] b,
                                input logic [31:0] qa, input logic [31:0] qb,
                                input logic ba, input logic bb, input logic [31:0] vec);
        vec_t v;
        v.we = we; v.aw = aw; v.di = di; v.iss = iss; v.ai = ai;
        v.a = a; v.b = b; v.qa = qa; v.qb = qb; v.ba = ba; v.bb = bb; v.vec = vec;
        return v;
    endfunction

    task automatic drive(input logic we, input logic [4:0] aw, input logic [31:0] di,
                         input logic iss, input logic [4:0] ai,
                         input logic [4:0] a, input logic [4:0] b);
        WE = we; Addr_W = aw; Di = di; Issue = iss; Addr_I = ai; Addr_A = a; Addr_B = b;
    endtask

    initial begin
        // Inputs applied at the falling edge; outputs compared 1ns later, i.e. they
        // reflect state captured at the previous rising edge.
        tv[0]  = mk(1, 5,  32'hDEADBEEF, 0, 0,  0,  31, 32'h0,        32'h0,        0, 0, 32'h0);
        tv[1]  = mk(1, 7,  32'h12345678, 0, 0,  5,  1,  32'hDEADBEEF, 32'h0,        0, 0, 32'h0);
        tv[2]  = mk(1, 0,  32'hFFFFFFFF, 1, 0,  5,  7,  32'hDEADBEEF, 32'h12345678, 0, 0, 32'h0);
        tv[3]  = mk(0, 0,  32'h0,        1, 9,  0,  0,  32'h0,        32'h0,        0, 0, 32'h0);
        tv[4]  = mk(0, 0,  32'h0,        0, 0,  9,  0,  32'h0,        32'h0,        1, 0, 32'h0000_0200);
        tv[5]  = mk(1, 9,  32'h000000A5, 1, 9,  5,  7,  32'hDEADBEEF, 32'h12345678, 0, 0, 32'h0000_0200);
        tv[6]  = mk(0, 0,  32'h0,        0, 0,  9,  9,  32'h000000A5, 32'h000000A5, 1, 1, 32'h0000_0200);
        tv[7]  = mk(1, 9,  32'h0000005A, 0, 0,  5,  0,  32'hDEADBEEF, 32'h0,        0, 0, 32'h0000_0200);
        tv[8]  = mk(0, 0,  32'h0,        0, 0,  9,  0,  32'h0000005A, 32'h0,        0, 0, 32'h0);
        tv[9]  = mk(0, 0,  32'h0,        1, 3,  0,  0,  32'h0,        32'h0,        0, 0, 32'h0);
        tv[10] = mk(1, 3,  32'h00000011, 1, 12, 12, 3,  32'h0,        32'h0,        0, 1, 32'h0000_0008);
        tv[11] = mk(0, 0,  32'h0,        0, 0,  3,  12, 32'h00000011, 32'h0,        0, 1, 32'h0000_1000);
        tv[12] = mk(0, 0,  32'h0,        1, 12, 12, 0,  32'h0,        32'h0,        1, 0, 32'h0000_1000);
        tv[13] = mk(1, 20, 32'h0BADF00D, 0, 0,  12, 0,  32'h0,        32'h0,        1, 0, 32'h0000_1000);
        tv[14] = mk(0, 0,  32'h0,        0, 0,  20, 12, 32'h0BADF00D, 32'h0,        0, 1, 32'h0000_1000);
        tv[15] = mk(1, 31, 32'h80000001, 0, 0,  20, 0,  32'h0BADF00D, 32'h0,        0, 0, 32'h0000_1000);
        tv[16] = mk(0, 0,  32'h0,        0, 0,  31, 31, 32'h80000001, 32'h80000001, 0, 0, 32'h0000_1000);

        cr = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        chk("rst_busy_vec", 0, Busy_vec, 32'h0);

        @(negedge clk);
        cr = 1'b1;
        for (int i = 0; i < 32; i++) begin
            Addr_A = 5'(i);
            Addr_B = 5'(31 - i);
            #1;
            chk("post_rst_qa", i, QA, 32'h0);
            chk("post_rst_qb", i, QB, 32'h0);
        end
        chk("post_rst_busy_vec", 0, Busy_vec, 32'h0);

        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            drive(tv[i].we, tv[i].aw, tv[i].di, tv[i].iss, tv[i].ai, tv[i].a, tv[i].b);
            #1;
            chk("qa", i, QA, tv[i].qa);
            chk("qb", i, QB, tv[i].qb);
            chk("busy_a", i, 32'(Busy_A), 32'(tv[i].ba));
            chk("busy_b", i, 32'(Busy_B), 32'(tv[i].bb));
            chk("busy_vec", i, Busy_vec, tv[i].vec);
        end

        // Same-cycle write and read of r3 (holds 0x11) while r3 is busy.
        @(negedge clk);
        drive(0, 0, 0, 1, 3, 0, 0);
        @(negedge clk);
        drive(1, 3, 32'h00000055, 0, 0, 3, 3);
        #1;
`ifdef REGS_FILE_BYPASS_EN
        chk("byp_qa", 0, QA, 32'h00000055);
        chk("byp_qb", 0, QB, 32'h00000055);
        chk("byp_busy_a", 0, 32'(Busy_A), 32'h0);
`else
        chk("byp_qa", 0, QA, 32'h00000011);
        chk("byp_qb", 0, QB, 32'h00000011);
        chk("byp_busy_a", 0, 32'(Busy_A), 32'h1);
`endif
        chk("byp_busy_vec", 0, Busy_vec, 32'h0000_1008);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 3, 0);
        #1;
        chk("after_byp_qa", 0, QA, 32'h00000055);
        chk("after_byp_busy_a", 0, 32'(Busy_A), 32'h0);

        // r4 = 0x77 and busy, then asynchronous reset mid-cycle.
        @(negedge clk);
        drive(1, 4, 32'h00000077, 0, 0, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 1, 4, 4, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 4, 12);
        #1;
        chk("pre_arst_qa", 0, QA, 32'h00000077);
        chk("pre_arst_busy_a", 0, 32'(Busy_A), 32'h1);
        chk("pre_arst_busy_vec", 0, Busy_vec, 32'h0000_1010);
        #1;
        cr = 1'b0;
        #1;
        chk("arst_qa", 0, QA, 32'h0);
        chk("arst_busy_a", 0, 32'(Busy_A), 32'h0);
        chk("arst_busy_vec", 0, Busy_vec, 32'h0);

        // First write after release lands on the next rising edge.
        @(negedge clk);
        cr = 1'b1;
        drive(1, 4, 32'h00000099, 0, 0, 4, 0);
        #1;
        chk("rel_qa_before", 0, QA, 32'h0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 4, 0);
        #1;
        chk("rel_qa_after", 0, QA, 32'h00000099);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
